// File: rtl/stu_upstream_rx_if.sv
// PE upstream ports plus the merged stream toward the stack system controller.
// slave is the receiver's view; master is the PE/controller environment's view.
interface stu_upstream_rx_if #(
    parameter int unsigned NUM_PE = 4,
    parameter int unsigned ID_W   = 2,
    parameter int unsigned CNTL_W = 2,
    parameter int unsigned TYPE_W = 2,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned OOB_W  = 32
);
    logic [NUM_PE-1:0]        pe__stu__valid;
    logic [NUM_PE*CNTL_W-1:0] pe__stu__cntl;
    logic [NUM_PE*TYPE_W-1:0] pe__stu__type;
    logic [NUM_PE*DATA_W-1:0] pe__stu__data;
    logic [NUM_PE*OOB_W-1:0]  pe__stu__oob_data;
    logic [NUM_PE-1:0]        stu__pe__ready;

    logic                     stu__sys__valid;
    logic [CNTL_W-1:0]        stu__sys__cntl;
    logic [TYPE_W-1:0]        stu__sys__type;
    logic [DATA_W-1:0]        stu__sys__data;
    logic [OOB_W-1:0]         stu__sys__oob_data;
    logic [ID_W-1:0]          stu__sys__peId;
    logic                     sys__stu__ready;
    logic                     stu__sys__protocol_err;

    modport slave (
        input  pe__stu__valid, pe__stu__cntl, pe__stu__type, pe__stu__data,
               pe__stu__oob_data, sys__stu__ready,
        output stu__pe__ready, stu__sys__valid, stu__sys__cntl, stu__sys__type,
               stu__sys__data, stu__sys__oob_data, stu__sys__peId,
               stu__sys__protocol_err
    );

    modport master (
        output pe__stu__valid, pe__stu__cntl, pe__stu__type, pe__stu__data,
               pe__stu__oob_data, sys__stu__ready,
        input  stu__pe__ready, stu__sys__valid, stu__sys__cntl, stu__sys__type,
               stu__sys__data, stu__sys__oob_data, stu__sys__peId,
               stu__sys__protocol_err
    );
endinterface

// File: rtl/stu_upstream_rx.sv
// Stack-side upstream receiver: packet-granular round-robin merge of NUM_PE PE
// ports into one PE-tagged stream through a show-ahead FIFO.
module stu_upstream_rx #(
    parameter int unsigned NUM_PE = 4,
    parameter int unsigned ID_W   = 2,
    parameter int unsigned CNTL_W = 2,
    parameter int unsigned TYPE_W = 2,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned OOB_W  = 32,
    parameter int unsigned DEPTH  = 8
) (
    input  logic             clk,
    input  logic             reset_poweron,
    stu_upstream_rx_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ENT_W = ID_W + CNTL_W + TYPE_W + DATA_W + OOB_W;

    localparam logic [CNTL_W-1:0] CNTL_MOM     = CNTL_W'(2'b00);
    localparam logic [CNTL_W-1:0] CNTL_SOM     = CNTL_W'(2'b01);
    localparam logic [CNTL_W-1:0] CNTL_EOM     = CNTL_W'(2'b10);
    localparam logic [CNTL_W-1:0] CNTL_SOM_EOM = CNTL_W'(2'b11);

    typedef enum logic {ST_IDLE, ST_LOCKED} state_e;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     grant_q, grant_d;
    logic [ID_W-1:0]     last_q, last_d;
    logic                discard_q, discard_d;
    logic                err_q, err_d;
    logic [NUM_PE-1:0]   ready_q, ready_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic [ENT_W-1:0]    mem [DEPTH];
    logic [ENT_W-1:0]    wr_entry;
    logic [ENT_W-1:0]    head_c;
    logic                push;
    logic                pop;
    logic                accept;

    logic [CNTL_W-1:0]   pe_cntl [NUM_PE];
    logic [TYPE_W-1:0]   pe_type [NUM_PE];
    logic [DATA_W-1:0]   pe_data [NUM_PE];
    logic [OOB_W-1:0]    pe_oob  [NUM_PE];

    logic                pick_found;
    logic [ID_W-1:0]     pick_idx;
    logic [ID_W-1:0]     cand;

    // Unpack the flat per-PE buses.
    always_comb begin
        for (int unsigned i = 0; i < NUM_PE; i++) begin
            pe_cntl[i] = bus.pe__stu__cntl[i*CNTL_W +: CNTL_W];
            pe_type[i] = bus.pe__stu__type[i*TYPE_W +: TYPE_W];
            pe_data[i] = bus.pe__stu__data[i*DATA_W +: DATA_W];
            pe_oob[i]  = bus.pe__stu__oob_data[i*OOB_W +: OOB_W];
        end
    end

    // Round-robin pick: first valid port after the last granted one, with wrap.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned i = 1; i <= NUM_PE; i++) begin
            cand = last_q + ID_W'(i);
            if (!pick_found && bus.pe__stu__valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        discard_d = discard_q;
        err_d     = err_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        ready_d   = '0;
        accept    = 1'b0;
        push      = 1'b0;
        pop       = (count_q != '0) && bus.sys__stu__ready;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = ST_LOCKED;
                    // A packet that opens mid-message is swallowed up to its EOM.
                    if (pe_cntl[pick_idx] == CNTL_MOM || pe_cntl[pick_idx] == CNTL_EOM) begin
                        discard_d = 1'b1;
                        err_d     = 1'b1;
                    end
                end
            end
            ST_LOCKED: begin
                accept = bus.pe__stu__valid[grant_q] && ready_q[grant_q];
                if (accept) begin
                    push = !discard_q;
                    if (!discard_q && pe_cntl[grant_q] == CNTL_SOM) begin
                        err_d = 1'b1;
                    end
                    if (pe_cntl[grant_q] == CNTL_EOM || pe_cntl[grant_q] == CNTL_SOM_EOM) begin
                        state_d   = ST_IDLE;
                        last_d    = grant_q;
                        discard_d = 1'b0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        // Ready is registered from next-cycle state, so it reflects the registered count.
        if (state_d == ST_LOCKED && count_d != CNT_W'(DEPTH)) begin
            ready_d[grant_d] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            last_q    <= ID_W'(NUM_PE - 1);
            discard_q <= 1'b0;
            err_q     <= 1'b0;
            ready_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            discard_q <= discard_d;
            err_q     <= err_d;
            ready_q   <= ready_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    assign wr_entry = {grant_q, pe_cntl[grant_q], pe_type[grant_q], pe_data[grant_q], pe_oob[grant_q]};

    // Storage is not reset; the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_entry;
        end
    end

    assign head_c = (count_q != '0) ? mem[rd_ptr_q] : '0;

    assign bus.stu__pe__ready         = ready_q;
    assign bus.stu__sys__valid        = (count_q != '0);
    assign bus.stu__sys__protocol_err = err_q;
    assign {bus.stu__sys__peId, bus.stu__sys__cntl, bus.stu__sys__type,
            bus.stu__sys__data, bus.stu__sys__oob_data} = head_c;
endmodule

// File: tb/tb_stu_upstream_rx.sv
// Randomized self-checking bench for stu_upstream_rx against a queue-based packet model.
module tb_stu_upstream_rx;
    localparam int unsigned NUM_PE = 4;
    localparam int unsigned ID_W   = 2;
    localparam int unsigned CNTL_W = 2;
    localparam int unsigned TYPE_W = 2;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned OOB_W  = 32;
    localparam int unsigned DEPTH  = 8;

    typedef struct packed {
        logic [1:0]  cntl;
        logic [1:0]  typ;
        logic [63:0] data;
        logic [31:0] oob;
    } beat_t;

    typedef struct packed {
        logic [1:0] pe;
        beat_t      b;
    } out_t;

    logic clk = 1'b0;
    logic reset_poweron = 1'b1;
    always #5 clk = ~clk;

    stu_upstream_rx_if #(.NUM_PE(NUM_PE), .ID_W(ID_W), .CNTL_W(CNTL_W), .TYPE_W(TYPE_W),
                         .DATA_W(DATA_W), .OOB_W(OOB_W)) bus ();

    stu_upstream_rx #(.NUM_PE(NUM_PE), .ID_W(ID_W), .CNTL_W(CNTL_W), .TYPE_W(TYPE_W),
                      .DATA_W(DATA_W), .OOB_W(OOB_W), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset_poweron (reset_poweron),
        .bus           (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Stimulus queues per PE and the model's view of the output FIFO.
    beat_t txq [NUM_PE][$];
    out_t  mq[$];
    bit    m_locked, m_discard, m_err, chk_en;
    int    m_grant, m_last;
    int    acc_cnt [NUM_PE];
    int    vprob = 100;
    int    sprob = 100;

    logic [NUM_PE-1:0] er;
    out_t              o, ob;
    logic [1:0]        wc;

    // Check outputs, then advance the packet-level model by one clock.
    always @(negedge clk) begin
        er = '0;
        if (m_locked && mq.size() < DEPTH) er[m_grant] = 1'b1;
        o = (mq.size() != 0) ? mq[0] : '0;
        if (chk_en) begin
            chk("ready", bus.stu__pe__ready, er);
            chk("sys_valid", bus.stu__sys__valid, mq.size() != 0);
            chk("peId", bus.stu__sys__peId, o.pe);
            chk("cntl", bus.stu__sys__cntl, o.b.cntl);
            chk("type", bus.stu__sys__type, o.b.typ);
            chk("data", bus.stu__sys__data, o.b.data);
            chk("oob", bus.stu__sys__oob_data, o.b.oob);
            chk("protocol_err", bus.stu__sys__protocol_err, m_err);
        end
        if (reset_poweron) begin
            mq.delete();
            m_locked  = 1'b0;
            m_discard = 1'b0;
            m_err     = 1'b0;
            m_grant   = 0;
            m_last    = NUM_PE - 1;
            chk_en    = 1'b1;
        end else if (chk_en) begin
            if (mq.size() != 0 && bus.sys__stu__ready) void'(mq.pop_front());
            if (m_locked) begin
                if (bus.pe__stu__valid[m_grant] && er[m_grant]) begin
                    wc = bus.pe__stu__cntl[m_grant*2 +: 2];
                    if (!m_discard) begin
                        ob.pe     = 2'(m_grant);
                        ob.b.cntl = wc;
                        ob.b.typ  = bus.pe__stu__type[m_grant*2 +: 2];
                        ob.b.data = bus.pe__stu__data[m_grant*64 +: 64];
                        ob.b.oob  = bus.pe__stu__oob_data[m_grant*32 +: 32];
                        mq.push_back(ob);
                        if (wc == 2'b01) m_err = 1'b1;
                    end
                    if (wc[1]) begin
                        m_locked  = 1'b0;
                        m_last    = m_grant;
                        m_discard = 1'b0;
                    end
                end
            end else begin
                for (int k = 1; k <= NUM_PE; k++) begin
                    if (!m_locked && bus.pe__stu__valid[(m_last + k) % NUM_PE]) begin
                        m_locked = 1'b1;
                        m_grant  = (m_last + k) % NUM_PE;
                        wc = bus.pe__stu__cntl[m_grant*2 +: 2];
                        if (wc == 2'b00 || wc == 2'b10) begin
                            m_discard = 1'b1;
                            m_err     = 1'b1;
                        end
                    end
                end
            end
            for (int i = 0; i < NUM_PE; i++) begin
                if (bus.pe__stu__valid[i] && bus.stu__pe__ready[i]) begin
                    acc_cnt[i]++;
                    if (txq[i].size() != 0) void'(txq[i].pop_front());
                end
            end
        end
    end

    task automatic drive();
        logic [NUM_PE-1:0]  v;
        logic [NUM_PE*2-1:0] c, t;
        logic [NUM_PE*64-1:0] d;
        logic [NUM_PE*32-1:0] ob_v;
        v = '0; c = '0; t = '0; d = '0; ob_v = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            if (txq[i].size() != 0) begin
                v[i]             = ($urandom_range(99) < vprob);
                c[i*2 +: 2]      = txq[i][0].cntl;
                t[i*2 +: 2]      = txq[i][0].typ;
                d[i*64 +: 64]    = txq[i][0].data;
                ob_v[i*32 +: 32] = txq[i][0].oob;
            end
        end
        bus.pe__stu__valid    = v;
        bus.pe__stu__cntl     = c;
        bus.pe__stu__type     = t;
        bus.pe__stu__data     = d;
        bus.pe__stu__oob_data = ob_v;
        bus.sys__stu__ready   = ($urandom_range(99) < sprob);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_poweron = 1'b1;
        for (int i = 0; i < NUM_PE; i++) txq[i].delete();
        drive();
        step();
        reset_poweron = 1'b0;
    endtask

    task automatic add_beat(input int pe, input logic [1:0] cntl, input logic [63:0] data);
        beat_t b;
        b.cntl = cntl;
        b.typ  = 2'($urandom_range(3));
        b.data = data;
        b.oob  = $urandom;
        txq[pe].push_back(b);
    endtask

    task automatic add_rand_pkt(input int pe);
        int len;
        logic [1:0] c;
        len = $urandom_range(1, 5);
        for (int k = 0; k < len; k++) begin
            if (len == 1)           c = 2'b11;
            else if (k == 0)        c = 2'b01;
            else if (k == len - 1)  c = 2'b10;
            else                    c = 2'b00;
            if (k == 0 && $urandom_range(11) == 0) c = (len == 1) ? 2'b10 : 2'b00;
            if (k != 0 && k != len - 1 && $urandom_range(19) == 0) c = 2'b01;
            add_beat(pe, c, {$urandom, $urandom});
        end
    endtask

    task automatic drain(input string tag, input int budget);
        bit done;
        done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            step();
            done = !m_locked && mq.size() == 0 && !bus.pe__stu__valid;
            for (int i = 0; i < NUM_PE; i++) if (txq[i].size() != 0) done = 1'b0;
        end
        chk(tag, done, 1'b1);
    endtask

    int base;

    initial begin
        bus.pe__stu__valid    = '0;
        bus.pe__stu__cntl     = '0;
        bus.pe__stu__type     = '0;
        bus.pe__stu__data     = '0;
        bus.pe__stu__oob_data = '0;
        bus.sys__stu__ready   = 1'b0;
        for (int i = 0; i < NUM_PE; i++) acc_cnt[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        reset_poweron = 1'b0;
        step();

        // Single packet from PE2.
        base = acc_cnt[2];
        add_beat(2, 2'b01, 64'hA0);
        add_beat(2, 2'b00, 64'hA1);
        add_beat(2, 2'b10, 64'hA2);
        drain("single_drain", 50);
        chk("single_accepted", 32'(acc_cnt[2] - base), 32'd3);

        // Contention from reset: PE0 wins over PE3.
        do_reset();
        add_beat(0, 2'b01, 64'hB0);
        add_beat(0, 2'b10, 64'hB1);
        add_beat(3, 2'b01, 64'hC0);
        add_beat(3, 2'b10, 64'hC1);
        drain("contention_drain", 50);

        // Backpressure: 12-beat packet into an 8-deep FIFO with sys stalled.
        sprob = 0;
        base  = acc_cnt[1];
        add_beat(1, 2'b01, 64'h100);
        for (int k = 1; k < 11; k++) add_beat(1, 2'b00, 64'(256 + k));
        add_beat(1, 2'b10, 64'h10B);
        repeat (25) step();
        chk("bp_accepted", 32'(acc_cnt[1] - base), 32'd8);
        sprob = 100;
        step();
        sprob = 0;
        repeat (4) step();
        chk("bp_one_pop", 32'(acc_cnt[1] - base), 32'd9);
        sprob = 100;
        drain("bp_drain", 80);
        chk("bp_total", 32'(acc_cnt[1] - base), 32'd12);

        // Protocol error: packet opening with MOM is dropped, next one passes.
        add_beat(1, 2'b00, 64'h55);
        add_beat(1, 2'b10, 64'h56);
        add_beat(1, 2'b11, 64'h57);
        drain("perr_drain", 50);
        chk("perr_sticky", bus.stu__sys__protocol_err, 1'b1);

        // Reset after two of four beats from PE0.
        base = acc_cnt[0];
        add_beat(0, 2'b01, 64'hD0);
        add_beat(0, 2'b00, 64'hD1);
        add_beat(0, 2'b00, 64'hD2);
        add_beat(0, 2'b10, 64'hD3);
        for (int c = 0; c < 40 && (acc_cnt[0] - base) < 2; c++) step();
        chk("rst_two_beats", 32'(acc_cnt[0] - base), 32'd2);
        do_reset();
        add_beat(0, 2'b01, 64'hE0);
        add_beat(0, 2'b10, 64'hE1);
        drain("rst_drain", 50);

        // Randomized traffic with random valid gaps and sys backpressure.
        vprob = 70;
        for (int c = 0; c < 2000; c++) begin
            if (c % 200 == 0) sprob = $urandom_range(20, 100);
            if ($urandom_range(3) == 0) begin
                int p;
                p = $urandom_range(NUM_PE - 1);
                if (txq[p].size() < 10) add_rand_pkt(p);
            end
            step();
        end
        vprob = 100;
        sprob = 100;
        drain("random_drain", 2000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
